lsu_dccm_arb: RTL and testbench

Port scheduler for the single-ported DCCM bank array. Each cycle it grants the DCCM to exactly one of three requesters: LSU pipe read (DC1), store-buffer drain write, or DMA read/write. It drives the DCCM memory's `dccm_wren`/`dccm_rden`/address/data inputs and returns DMA read data. LSU reads win by default; a starvation guard periodically stalls the LSU so writers make progress.

---
 rtl/lsu_dccm_arb_pkg.sv | 22 ++
 rtl/lsu_dccm_starve_ctr.sv | 48 ++++
 rtl/lsu_dccm_arb.sv | 236 +++++++++++++++++++++++
 tb/tb_lsu_dccm_arb.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_dccm_arb_pkg.sv
// Shared types and sizes for the DCCM port scheduler.
package lsu_dccm_arb_pkg;

    localparam int RV_DCCM_BITS        = 16;
    localparam int RV_DCCM_FDATA_WIDTH = 39;
    localparam int STARVE_CNT_W        = 4;

    // Which requester owns the DCCM port this cycle.
    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_LSU   = 2'd1,
        SRC_STBUF = 2'd2,
        SRC_DMA   = 2'd3
    } dccm_src_e;

    // NORMAL lets LSU reads win; FORCE is a one-cycle LSU stall for a starved writer.
    typedef enum logic {
        ARB_NORMAL = 1'b0,
        ARB_FORCE  = 1'b1
    } dccm_arb_state_e;

endpackage

// File: rtl/lsu_dccm_starve_ctr.sv
// Saturating starvation counter for one DCCM writer.
// o_starved looks at the current count, o_starved_nx at the count being loaded,
// so the scheduler can arm a FORCE slot for the cycle right after the limit is reached.
module lsu_dccm_starve_ctr
    import lsu_dccm_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst_l,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_starved,
    output logic o_starved_nx
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(STARVE_LIMIT);
    localparam logic [STARVE_CNT_W-1:0] CNT_MAX = {STARVE_CNT_W{1'b1}};
    localparam logic [STARVE_CNT_W-1:0] CNT_ONE = STARVE_CNT_W'(1);

    logic [STARVE_CNT_W-1:0] r_count;
    logic [STARVE_CNT_W-1:0] w_count_nx;

    // Next count: clear wins over increment, increment saturates, otherwise hold.
    always_comb begin
        w_count_nx = r_count;
        if (i_clr) begin
            w_count_nx = {STARVE_CNT_W{1'b0}};
        end else if (i_inc && (r_count != CNT_MAX)) begin
            w_count_nx = r_count + CNT_ONE;
        end else begin
            w_count_nx = r_count;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_count <= {STARVE_CNT_W{1'b0}};
        end else begin
            r_count <= w_count_nx;
        end
    end

    assign o_starved    = (r_count >= LIMIT_C);
    assign o_starved_nx = (w_count_nx >= LIMIT_C);

endmodule

// File: rtl/lsu_dccm_arb.sv
// DCCM port scheduler: one grant per cycle among LSU read, store-buffer drain
// and DMA. LSU reads win unless a writer has been starved, in which case the
// LSU is stalled for exactly one FORCE cycle. Grants and DCCM drive are
// combinational; only the DMA read response is registered.
module lsu_dccm_arb
    import lsu_dccm_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int DMA_TAG_W    = 3
) (
    input  logic                           clk,
    input  logic                           rst_l,
    input  logic                           lsu_freeze_dc3,
    input  logic                           lsu_rd_valid,
    input  logic [RV_DCCM_BITS-1:0]        lsu_rd_addr_lo,
    input  logic [RV_DCCM_BITS-1:0]        lsu_rd_addr_hi,
    output logic                           lsu_dccm_stall,
    input  logic                           stbuf_valid,
    input  logic [RV_DCCM_BITS-1:0]        stbuf_addr,
    input  logic [RV_DCCM_FDATA_WIDTH-1:0] stbuf_data,
    output logic                           stbuf_ready,
    input  logic                           dma_valid,
    input  logic                           dma_write,
    input  logic [RV_DCCM_BITS-1:0]        dma_addr,
    input  logic [RV_DCCM_FDATA_WIDTH-1:0] dma_wdata,
    input  logic [DMA_TAG_W-1:0]           dma_tag,
    output logic                           dma_ready,
    output logic                           dma_rsp_valid,
    output logic [DMA_TAG_W-1:0]           dma_rsp_tag,
    output logic [RV_DCCM_FDATA_WIDTH-1:0] dma_rsp_data,
    input  logic [RV_DCCM_FDATA_WIDTH-1:0] dccm_rd_data_lo,
    output logic                           dccm_wren,
    output logic                           dccm_rden,
    output logic [RV_DCCM_BITS-1:0]        dccm_wr_addr,
    output logic [RV_DCCM_BITS-1:0]        dccm_rd_addr_lo,
    output logic [RV_DCCM_BITS-1:0]        dccm_rd_addr_hi,
    output logic [RV_DCCM_FDATA_WIDTH-1:0] dccm_wr_data
);

    dccm_arb_state_e        r_state;
    dccm_arb_state_e        w_next_state;
    dccm_src_e              w_src;
    logic                   r_rr;
    logic                   w_active;
    logic                   w_writer_grant;
    logic                   w_dma_rd_grant;
    logic                   w_st_inc;
    logic                   w_st_clr;
    logic                   w_dma_inc;
    logic                   w_dma_clr;
    logic                   w_st_starved;
    logic                   w_st_starved_nx;
    logic                   w_dma_starved;
    logic                   w_dma_starved_nx;
    logic                   w_force_st;
    logic                   w_force_dma;
    logic                   r_rsp_valid;
    logic [DMA_TAG_W-1:0]   r_rsp_tag;

    // Freeze suspends all grants and all bookkeeping (counters, rr, state).
    assign w_active    = ~lsu_freeze_dc3;
    assign w_force_st  = stbuf_valid & w_st_starved;
    assign w_force_dma = dma_valid & w_dma_starved;

    // Grant selection for the current cycle.
    always_comb begin
        w_src = SRC_NONE;
        if (lsu_freeze_dc3) begin
            w_src = SRC_NONE;
        end else begin
            case (r_state)
                ARB_FORCE: begin
                    if (w_force_st && w_force_dma) begin
                        w_src = r_rr ? SRC_DMA : SRC_STBUF;
                    end else if (w_force_st) begin
                        w_src = SRC_STBUF;
                    end else if (w_force_dma) begin
                        w_src = SRC_DMA;
                    end else begin
                        w_src = SRC_NONE;
                    end
                end
                ARB_NORMAL: begin
                    if (lsu_rd_valid) begin
                        w_src = SRC_LSU;
                    end else if (stbuf_valid && dma_valid) begin
                        w_src = r_rr ? SRC_DMA : SRC_STBUF;
                    end else if (stbuf_valid) begin
                        w_src = SRC_STBUF;
                    end else if (dma_valid) begin
                        w_src = SRC_DMA;
                    end else begin
                        w_src = SRC_NONE;
                    end
                end
                default: begin
                    w_src = SRC_NONE;
                end
            endcase
        end
    end

    assign w_writer_grant = (w_src == SRC_STBUF) | (w_src == SRC_DMA);
    assign w_dma_rd_grant = (w_src == SRC_DMA) & ~dma_write;

    // A writer counts a cycle as starved only while it is requesting and loses.
    assign w_st_inc  = w_active & stbuf_valid & (w_src != SRC_STBUF);
    assign w_st_clr  = w_active & (~stbuf_valid | (w_src == SRC_STBUF));
    assign w_dma_inc = w_active & dma_valid & (w_src != SRC_DMA);
    assign w_dma_clr = w_active & (~dma_valid | (w_src == SRC_DMA));

    lsu_dccm_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_st_ctr (
        .clk          (clk),
        .rst_l        (rst_l),
        .i_inc        (w_st_inc),
        .i_clr        (w_st_clr),
        .o_starved    (w_st_starved),
        .o_starved_nx (w_st_starved_nx)
    );

    lsu_dccm_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_dma_ctr (
        .clk          (clk),
        .rst_l        (rst_l),
        .i_inc        (w_dma_inc),
        .i_clr        (w_dma_clr),
        .o_starved    (w_dma_starved),
        .o_starved_nx (w_dma_starved_nx)
    );

    // Next state: arm FORCE once a writer reaches the limit while the LSU keeps
    // the port; FORCE is one unfrozen cycle long and is held across freeze.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ARB_NORMAL: begin
                if (w_active && lsu_rd_valid && (w_st_starved_nx || w_dma_starved_nx)) begin
                    w_next_state = ARB_FORCE;
                end else begin
                    w_next_state = ARB_NORMAL;
                end
            end
            ARB_FORCE: begin
                if (lsu_freeze_dc3) begin
                    w_next_state = ARB_FORCE;
                end else begin
                    w_next_state = ARB_NORMAL;
                end
            end
            default: begin
                w_next_state = ARB_NORMAL;
            end
        endcase
    end

    // Scheduler state register.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state <= ARB_NORMAL;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Round-robin pointer between the two writers; flips on every writer grant.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_rr <= 1'b0;
        end else if (w_writer_grant) begin
            r_rr <= ~r_rr;
        end else begin
            r_rr <= r_rr;
        end
    end

    // DCCM port drive for the granted requester; idle fields stay at zero.
    always_comb begin
        dccm_wren       = 1'b0;
        dccm_rden       = 1'b0;
        dccm_wr_addr    = {RV_DCCM_BITS{1'b0}};
        dccm_rd_addr_lo = {RV_DCCM_BITS{1'b0}};
        dccm_rd_addr_hi = {RV_DCCM_BITS{1'b0}};
        dccm_wr_data    = {RV_DCCM_FDATA_WIDTH{1'b0}};
        case (w_src)
            SRC_LSU: begin
                dccm_rden       = 1'b1;
                dccm_rd_addr_lo = lsu_rd_addr_lo;
                dccm_rd_addr_hi = lsu_rd_addr_hi;
            end
            SRC_STBUF: begin
                dccm_wren    = 1'b1;
                dccm_wr_addr = stbuf_addr;
                dccm_wr_data = stbuf_data;
            end
            SRC_DMA: begin
                if (dma_write) begin
                    dccm_wren    = 1'b1;
                    dccm_wr_addr = dma_addr;
                    dccm_wr_data = dma_wdata;
                end else begin
                    // DMA accesses are aligned, so both banks see the same address.
                    dccm_rden       = 1'b1;
                    dccm_rd_addr_lo = dma_addr;
                    dccm_rd_addr_hi = dma_addr;
                end
            end
            default: begin
                dccm_wren = 1'b0;
                dccm_rden = 1'b0;
            end
        endcase
    end

    assign lsu_dccm_stall = lsu_rd_valid & (w_src != SRC_LSU);
    assign stbuf_ready    = (w_src == SRC_STBUF);
    assign dma_ready      = (w_src == SRC_DMA);

    // DMA read response tracking: valid one cycle after the grant, tag captured at grant.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_rsp_valid <= 1'b0;
            r_rsp_tag   <= {DMA_TAG_W{1'b0}};
        end else if (w_dma_rd_grant) begin
            r_rsp_valid <= 1'b1;
            r_rsp_tag   <= dma_tag;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_tag   <= r_rsp_tag;
        end
    end

    // The DCCM returns lo-bank data in the response cycle; pass it through only then.
    assign dma_rsp_valid = r_rsp_valid;
    assign dma_rsp_tag   = r_rsp_tag;
    assign dma_rsp_data  = r_rsp_valid ? dccm_rd_data_lo : {RV_DCCM_FDATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_lsu_dccm_arb.sv
// Directed bench for lsu_dccm_arb: a per-cycle vector table for the single-cycle
// grant behaviour, then hand-written sequences for response timing, starvation,
// freeze and reset corner cases.
module tb_lsu_dccm_arb;
    import lsu_dccm_arb_pkg::*;

    localparam int AW = RV_DCCM_BITS;
    localparam int DW = RV_DCCM_FDATA_WIDTH;
    localparam int TW = 3;
    localparam int NV = 13;

    logic          clk;
    logic          rst_l;
    logic          lsu_freeze_dc3;
    logic          lsu_rd_valid;
    logic [AW-1:0] lsu_rd_addr_lo;
    logic [AW-1:0] lsu_rd_addr_hi;
    logic          lsu_dccm_stall;
    logic          stbuf_valid;
    logic [AW-1:0] stbuf_addr;
    logic [DW-1:0] stbuf_data;
    logic          stbuf_ready;
    logic          dma_valid;
    logic          dma_write;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic [TW-1:0] dma_tag;
    logic          dma_ready;
    logic          dma_rsp_valid;
    logic [TW-1:0] dma_rsp_tag;
    logic [DW-1:0] dma_rsp_data;
    logic [DW-1:0] dccm_rd_data_lo;
    logic          dccm_wren;
    logic          dccm_rden;
    logic [AW-1:0] dccm_wr_addr;
    logic [AW-1:0] dccm_rd_addr_lo;
    logic [AW-1:0] dccm_rd_addr_hi;
    logic [DW-1:0] dccm_wr_data;

    int n_checks = 0;
    int n_errors = 0;

    lsu_dccm_arb #(.STARVE_LIMIT(4), .DMA_TAG_W(TW)) dut (
        .clk             (clk),
        .rst_l           (rst_l),
        .lsu_freeze_dc3  (lsu_freeze_dc3),
        .lsu_rd_valid    (lsu_rd_valid),
        .lsu_rd_addr_lo  (lsu_rd_addr_lo),
        .lsu_rd_addr_hi  (lsu_rd_addr_hi),
        .lsu_dccm_stall  (lsu_dccm_stall),
        .stbuf_valid     (stbuf_valid),
        .stbuf_addr      (stbuf_addr),
        .stbuf_data      (stbuf_data),
        .stbuf_ready     (stbuf_ready),
        .dma_valid       (dma_valid),
        .dma_write       (dma_write),
        .dma_addr        (dma_addr),
        .dma_wdata       (dma_wdata),
        .dma_tag         (dma_tag),
        .dma_ready       (dma_ready),
        .dma_rsp_valid   (dma_rsp_valid),
        .dma_rsp_tag     (dma_rsp_tag),
        .dma_rsp_data    (dma_rsp_data),
        .dccm_rd_data_lo (dccm_rd_data_lo),
        .dccm_wren       (dccm_wren),
        .dccm_rden       (dccm_rden),
        .dccm_wr_addr    (dccm_wr_addr),
        .dccm_rd_addr_lo (dccm_rd_addr_lo),
        .dccm_rd_addr_hi (dccm_rd_addr_hi),
        .dccm_wr_data    (dccm_wr_data)
    );

    // Free-running core clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence below ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        string         nm;
        logic          frz;
        logic          lv;
        logic [AW-1:0] llo;
        logic [AW-1:0] lhi;
        logic          sv;
        logic [AW-1:0] sa;
        logic [DW-1:0] sd;
        logic          dv;
        logic          dw;
        logic [AW-1:0] da;
        logic [DW-1:0] dd;
        logic [TW-1:0] dt;
        logic          e_stall;
        logic          e_sr;
        logic          e_dr;
        logic          e_wren;
        logic          e_rden;
        logic [AW-1:0] e_wa;
        logic [AW-1:0] e_rlo;
        logic [AW-1:0] e_rhi;
        logic [DW-1:0] e_wd;
    } vec_t;

    vec_t vecs[NV];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        lsu_freeze_dc3  = 1'b0;
        lsu_rd_valid    = 1'b0;
        lsu_rd_addr_lo  = 16'h0000;
        lsu_rd_addr_hi  = 16'h0000;
        stbuf_valid     = 1'b0;
        stbuf_addr      = 16'h0000;
        stbuf_data      = 39'h0;
        dma_valid       = 1'b0;
        dma_write       = 1'b0;
        dma_addr        = 16'h0000;
        dma_wdata       = 39'h0;
        dma_tag         = 3'd0;
        dccm_rd_data_lo = 39'h0;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        rst_l = 1'b0;
        step();
        step();
        rst_l = 1'b1;
    endtask

    task automatic apply(input vec_t v);
        lsu_freeze_dc3 = v.frz;
        lsu_rd_valid   = v.lv;
        lsu_rd_addr_lo = v.llo;
        lsu_rd_addr_hi = v.lhi;
        stbuf_valid    = v.sv;
        stbuf_addr     = v.sa;
        stbuf_data     = v.sd;
        dma_valid      = v.dv;
        dma_write      = v.dw;
        dma_addr       = v.da;
        dma_wdata      = v.dd;
        dma_tag        = v.dt;
    endtask

    initial begin
        // nm, frz, lv, llo, lhi, sv, sa, sd, dv, dw, da, dd, dt,
        // e_stall, e_sr, e_dr, e_wren, e_rden, e_wa, e_rlo, e_rhi, e_wd
        vecs[0]  = '{"idle",       1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 39'h0,
                     1'b0, 1'b0, 16'h0000, 39'h0, 3'd0,
                     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 39'h0};
        vecs[1]  = '{"lsu_rd",     1'b0, 1'b1, 16'h0010, 16'h0014, 1'b0, 16'h0000, 39'h0,
                     1'b0, 1'b0, 16'h0000, 39'h0, 3'd0,
                     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0010, 16'h0014, 39'h0};
        vecs[2]  = '{"stbuf_wr",   1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0100, 39'h12_3456_789A,
                     1'b0, 1'b0, 16'h0000, 39'h0, 3'd0,
                     1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0100, 16'h0000, 16'h0000, 39'h12_3456_789A};
        vecs[3]  = '{"dma_wr",     1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 39'h0,
                     1'b1, 1'b1, 16'h0200, 39'h0A_BCDE_F012, 3'd1,
                     1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0200, 16'h0000, 16'h0000, 39'h0A_BCDE_F012};
        vecs[4]  = '{"rr_stbuf",   1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0104, 39'h111,
                     1'b1, 1'b1, 16'h0204, 39'h222, 3'd2,
                     1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0104, 16'h0000, 16'h0000, 39'h111};
        vecs[5]  = '{"rr_dma",     1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0104, 39'h111,
                     1'b1, 1'b1, 16'h0204, 39'h222, 3'd2,
                     1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0204, 16'h0000, 16'h0000, 39'h222};
        vecs[6]  = '{"rr_stbuf2",  1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0104, 39'h111,
                     1'b1, 1'b1, 16'h0204, 39'h222, 3'd2,
                     1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0104, 16'h0000, 16'h0000, 39'h111};
        vecs[7]  = '{"lsu_only",   1'b0, 1'b1, 16'h0020, 16'h0024, 1'b0, 16'h0000, 39'h0,
                     1'b0, 1'b0, 16'h0000, 39'h0, 3'd0,
                     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0020, 16'h0024, 39'h0};
        vecs[8]  = '{"frz_req",    1'b1, 1'b1, 16'h0030, 16'h0034, 1'b1, 16'h0108, 39'h333,
                     1'b0, 1'b0, 16'h0000, 39'h0, 3'd0,
                     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 39'h0};
        vecs[9]  = '{"frz_idle",   1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 39'h0,
                     1'b0, 1'b0, 16'h0000, 39'h0, 3'd0,
                     1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 39'h0};
        vecs[10] = '{"dma_rd",     1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 39'h0,
                     1'b1, 1'b0, 16'h0040, 39'h0, 3'd5,
                     1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0040, 16'h0040, 39'h0};
        vecs[11] = '{"lsu_vs_dma", 1'b0, 1'b1, 16'h0300, 16'h0304, 1'b0, 16'h0000, 39'h0,
                     1'b1, 1'b1, 16'h0300, 39'h444, 3'd3,
                     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0300, 16'h0304, 39'h0};
        vecs[12] = '{"dma_wr_lat", 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 39'h0,
                     1'b1, 1'b1, 16'h0300, 39'h444, 3'd3,
                     1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0300, 16'h0000, 16'h0000, 39'h444};

        // ---- reset values ----
        set_idle();
        rst_l = 1'b0;
        step();
        chk("rst.rsp_valid", dma_rsp_valid, 1'b0);
        chk("rst.rsp_tag",   dma_rsp_tag, 3'd0);
        chk("rst.rsp_data",  dma_rsp_data, 39'h0);
        chk("rst.stall",     lsu_dccm_stall, 1'b0);
        chk("rst.enables",   {dccm_wren, dccm_rden, stbuf_ready, dma_ready}, 4'h0);
        step();
        rst_l = 1'b1;

        // ---- vector table, one cycle per entry ----
        for (int i = 0; i < NV; i++) begin
            apply(vecs[i]);
            #3;
            chk({vecs[i].nm, ".stall"},  lsu_dccm_stall,  vecs[i].e_stall);
            chk({vecs[i].nm, ".sready"}, stbuf_ready,     vecs[i].e_sr);
            chk({vecs[i].nm, ".dready"}, dma_ready,       vecs[i].e_dr);
            chk({vecs[i].nm, ".wren"},   dccm_wren,       vecs[i].e_wren);
            chk({vecs[i].nm, ".rden"},   dccm_rden,       vecs[i].e_rden);
            chk({vecs[i].nm, ".waddr"},  dccm_wr_addr,    vecs[i].e_wa);
            chk({vecs[i].nm, ".rlo"},    dccm_rd_addr_lo, vecs[i].e_rlo);
            chk({vecs[i].nm, ".rhi"},    dccm_rd_addr_hi, vecs[i].e_rhi);
            chk({vecs[i].nm, ".wdata"},  dccm_wr_data,    vecs[i].e_wd);
            step();
        end

        // ---- DMA read response timing ----
        do_reset();
        dma_valid = 1'b1; dma_write = 1'b0; dma_addr = 16'h0040; dma_tag = 3'd6;
        #3;
        chk("rsp.grant_rden",  dccm_rden, 1'b1);
        chk("rsp.grant_ready", dma_ready, 1'b1);
        chk("rsp.grant_addr",  {dccm_rd_addr_lo, dccm_rd_addr_hi}, {16'h0040, 16'h0040});
        chk("rsp.n_valid",     dma_rsp_valid, 1'b0);
        step();
        set_idle();
        dccm_rd_data_lo = 39'h5A_5A5A;
        #3;
        chk("rsp.n1_valid", dma_rsp_valid, 1'b1);
        chk("rsp.n1_tag",   dma_rsp_tag, 3'd6);
        chk("rsp.n1_data",  dma_rsp_data, 39'h5A_5A5A);
        step();
        dccm_rd_data_lo = 39'h0;
        #3;
        chk("rsp.n2_valid", dma_rsp_valid, 1'b0);
        step();

        // back-to-back reads, freeze raised in the last response cycle
        dma_valid = 1'b1; dma_write = 1'b0; dma_addr = 16'h0044; dma_tag = 3'd1;
        step();
        dma_addr = 16'h0048; dma_tag = 3'd2; dccm_rd_data_lo = 39'h111;
        #3;
        chk("b2b.r1_valid", dma_rsp_valid, 1'b1);
        chk("b2b.r1_tag",   dma_rsp_tag, 3'd1);
        chk("b2b.r1_data",  dma_rsp_data, 39'h111);
        chk("b2b.g2_ready", dma_ready, 1'b1);
        step();
        set_idle();
        lsu_freeze_dc3 = 1'b1;
        dccm_rd_data_lo = 39'h222;
        #3;
        chk("b2b.r2_valid_frz", dma_rsp_valid, 1'b1);
        chk("b2b.r2_tag",       dma_rsp_tag, 3'd2);
        chk("b2b.r2_data",      dma_rsp_data, 39'h222);
        step();
        set_idle();
        #3;
        chk("b2b.r3_valid", dma_rsp_valid, 1'b0);

        // ---- stbuf starvation against a continuous LSU stream ----
        do_reset();
        lsu_rd_valid = 1'b1; lsu_rd_addr_lo = 16'h0050; lsu_rd_addr_hi = 16'h0054;
        stbuf_valid = 1'b1; stbuf_addr = 16'h0110; stbuf_data = 39'h77;
        for (int c = 1; c <= 6; c++) begin
            #3;
            chk($sformatf("starve.c%0d.stall", c),  lsu_dccm_stall, (c == 5) ? 1'b1 : 1'b0);
            chk($sformatf("starve.c%0d.sready", c), stbuf_ready,    (c == 5) ? 1'b1 : 1'b0);
            chk($sformatf("starve.c%0d.wren", c),   dccm_wren,      (c == 5) ? 1'b1 : 1'b0);
            step();
        end

        // ---- freeze holds counters ----
        do_reset();
        set_idle();
        lsu_rd_valid = 1'b1; stbuf_valid = 1'b1; stbuf_addr = 16'h0120; stbuf_data = 39'h88;
        step();
        step();
        lsu_freeze_dc3 = 1'b1; dma_valid = 1'b1; dma_write = 1'b1; dma_addr = 16'h0220;
        for (int c = 1; c <= 3; c++) begin
            #3;
            chk($sformatf("frz.c%0d.stall", c), lsu_dccm_stall, 1'b1);
            chk($sformatf("frz.c%0d.grants", c),
                {stbuf_ready, dma_ready, dccm_wren, dccm_rden}, 4'h0);
            step();
        end
        lsu_freeze_dc3 = 1'b0; dma_valid = 1'b0; dma_write = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            #3;
            chk($sformatf("unfrz.c%0d.sready", c), stbuf_ready, (c == 3) ? 1'b1 : 1'b0);
            chk($sformatf("unfrz.c%0d.stall", c),  lsu_dccm_stall, (c == 3) ? 1'b1 : 1'b0);
            step();
        end

        // ---- FORCE cycle hit by freeze is retried ----
        do_reset();
        lsu_rd_valid = 1'b1; stbuf_valid = 1'b1; stbuf_addr = 16'h0130; stbuf_data = 39'h99;
        for (int c = 1; c <= 4; c++) step();
        lsu_freeze_dc3 = 1'b1;
        #3;
        chk("frcfrz.frozen_sready", stbuf_ready, 1'b0);
        chk("frcfrz.frozen_stall",  lsu_dccm_stall, 1'b1);
        step();
        lsu_freeze_dc3 = 1'b0;
        #3;
        chk("frcfrz.retry_sready", stbuf_ready, 1'b1);
        chk("frcfrz.retry_stall",  lsu_dccm_stall, 1'b1);
        step();
        #3;
        chk("frcfrz.after_stall", lsu_dccm_stall, 1'b0);
        chk("frcfrz.after_rden",  dccm_rden, 1'b1);

        // ---- async reset straddling the response edge drops the response ----
        do_reset();
        dma_valid = 1'b1; dma_write = 1'b0; dma_addr = 16'h0060; dma_tag = 3'd4;
        #3;
        chk("arst.grant", dma_ready, 1'b1);
        #2;
        rst_l = 1'b0;
        set_idle();
        step();
        #3;
        chk("arst.rsp_valid_in_rst", dma_rsp_valid, 1'b0);
        rst_l = 1'b1;
        step();
        #3;
        chk("arst.rsp_valid_after", dma_rsp_valid, 1'b0);
        chk("arst.rsp_tag_after",   dma_rsp_tag, 3'd0);
        step();

        // ---- both writers starved behind a continuous LSU stream ----
        do_reset();
        lsu_rd_valid = 1'b1;
        stbuf_valid = 1'b1; stbuf_addr = 16'h0140; stbuf_data = 39'hAA;
        dma_valid = 1'b1; dma_write = 1'b1; dma_addr = 16'h0240; dma_wdata = 39'hBB;
        for (int c = 1; c <= 20; c++) begin
            logic exp_st;
            logic exp_dma;
            exp_st  = ((c % 5) == 0) ? 1'b1 : 1'b0;
            exp_dma = (((c % 5) == 2) && (c >= 7)) ? 1'b1 : 1'b0;
            #3;
            chk($sformatf("both.c%0d.sready", c), stbuf_ready, exp_st);
            chk($sformatf("both.c%0d.dready", c), dma_ready, exp_dma);
            chk($sformatf("both.c%0d.stall", c),  lsu_dccm_stall, exp_st | exp_dma);
            chk($sformatf("both.c%0d.excl", c),   dccm_wren & dccm_rden, 1'b0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
